uarc_receiver_arbiter: RTL
==========================

# uarc_receiver_arbiter

Shares the core's single inbound-message path among all UARC receiver buses. It takes kill, incept, send and stream requests from up to TOTAL_BUSES buses and grants one bus at a time, round-robin. The granted request's payload is captured into a holding register and offered to the core with a valid/ready handshake. After the core accepts, the arbiter returns a one-cycle ack on the matching receiver ack line.

## Interface
- WORD_MAG, 5: log2 of word width; WORD_WIDTH = 1 << WORD_MAG.
- TOTAL_BUSES, 4: number of receiver buses arbitrated (≥1).
- BUS_SEL_WIDTH, derived: max(1, $clog2(TOTAL_BUSES)).

Ports:
- clk  in  1  the single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- receiver_enables  in  TOTAL_BUSES  per-bus request valid.
- receiver_kills / receiver_incepts / receiver_sends / receiver_streams  in  TOTAL_BUSES each  per-bus request kind.
- receiver_datas / receiver_incept_permissions / receiver_incept_addresses  in  TOTAL_BUSES×WORD_WIDTH  per-bus payload.
- receiver_kill_acks / receiver_incept_acks / receiver_send_acks / receiver_stream_acks  out  TOTAL_BUSES each  one-cycle ack pulses.
- out_valid  out  1  captured request is offered to the core.
- out_ready  in  1  core accepts the offered request.
- out_kind  out  2  0=kill, 1=incept, 2=send, 3=stream.
- out_bus  out  BUS_SEL_WIDTH  index of the granted bus.
- out_data / out_permission / out_address  out  WORD_WIDTH each  captured payload. out_permission and out_address are zero unless out_kind is incept.

## Operation
- Bus i is eligible when receiver_enables[i] is high and at least one of its kind bits is high.
- Effective kind within a bus uses fixed priority: kill > incept > send > stream.
- State machine: IDLE, OFFER, ACK.
- **IDLE**
  - If any bus is eligible, grant the first eligible bus at or after rr_ptr, wrapping modulo TOTAL_BUSES.
  - Capture kind, bus and payload into the holding register, then go to OFFER.
  - If no bus is eligible, stay in IDLE.
- **OFFER**
  - out_valid = 1; the holding register stays stable.
  - If out_ready is high: go to ACK and set rr_ptr to (granted+1) mod TOTAL_BUSES. Wrap applies: with TOTAL_BUSES=4, a grant on bus 3 sets rr_ptr=0.
  - If the granted bus drops receiver_enables before acceptance: abort to IDLE with no ack and no rr_ptr change. out_ready in that same cycle is ignored.
- **ACK**
  - Exactly one ack bit is high for one cycle: the one matching the captured kind, on the granted bus.
  - out_valid = 0. Next state is always IDLE.
- Requester contract: hold the request and payload until ack is seen, and drop the request in the cycle after ack. The ACK→IDLE cycle guarantees the stale request is not re-granted.
- Reset values:
  - State IDLE, rr_ptr=0.
  - out_valid=0; out_kind, out_bus, out_data, out_permission, out_address all 0.
  - All ack outputs 0.
- Reset in OFFER or ACK discards the held request with no ack pulse.

## Timing
- Request eligible in IDLE at edge n → out_valid high from cycle n+1.
- out_ready sampled high at edge m → ack pulse during cycle m+1, with out_valid low in m+1.
- Earliest next grant is sampled at edge m+2; out_valid is high again at m+3.
- Peak throughput is one message per 3 cycles.
- out_ready while out_valid=0 has no effect.
- All outputs are registered; no combinational path from receiver_* or out_ready to any output.

## Configuration
- UARC_ARB_KILL_PREEMPT_EN defined: in IDLE, any bus with an eligible kill wins over all non-kill requests, regardless of rr_ptr. Round-robin order applies among kill requests, then among the rest. rr_ptr updates the same way.
- Not defined: pure round-robin over buses. A kill gets priority only within its own bus.

## Test plan
- **Single send.** Bus 2 requests send with data=0xDEADBEEF; out_ready held high.
  - out_valid, out_kind=2, out_bus=2, out_data=0xDEADBEEF one cycle later.
  - receiver_send_acks=4'b0100 for exactly one cycle.
- **Round-robin wrap.** Buses 0, 1 and 3 all request send continuously, each dropping its request after its ack and re-raising it one cycle later.
  - Grant order from reset is 0, 1, 3, 0, 1, 3.
- **Intra-bus priority.** Bus 1 asserts incept and stream together, permission=0x11, address=0x22.
  - out_kind=1, out_permission=0x11, out_address=0x22.
  - Only receiver_incept_acks[1] pulses.
- **Backpressure and abort.**
  - Hold out_ready low for 5 cycles: out_* stays stable and no ack is issued.
  - Drop bus enable during OFFER: the arbiter returns to IDLE with no ack and rr_ptr unchanged.
- **Reset mid-transaction.** Assert reset during OFFER and during ACK.
  - The next cycle has all outputs 0 and no ack pulse.
  - rr_ptr=0, so bus 0 is granted first afterwards.
- **UARC_ARB_KILL_PREEMPT_EN.** rr_ptr=1; bus 1 requests send while bus 3 requests kill.
  - With the macro defined: bus 3 is granted first.
  - Without the macro: bus 1 is granted first.

Source files
------------

// File: rtl/uarc_receiver_arbiter_if.sv
// Request/ack bundle shared by the UARC receiver buses, the receiver arbiter and the core.
// slave = arbiter view, master = requester/core view.
interface uarc_receiver_arbiter_if #(
  parameter int WORD_MAG    = 5,
  parameter int TOTAL_BUSES = 4
);
  localparam int WORD_WIDTH    = 1 << WORD_MAG;
  localparam int BUS_SEL_WIDTH = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

  logic [TOTAL_BUSES-1:0]                 receiver_enables;
  logic [TOTAL_BUSES-1:0]                 receiver_kills;
  logic [TOTAL_BUSES-1:0]                 receiver_incepts;
  logic [TOTAL_BUSES-1:0]                 receiver_sends;
  logic [TOTAL_BUSES-1:0]                 receiver_streams;
  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas;
  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_incept_permissions;
  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_incept_addresses;
  logic [TOTAL_BUSES-1:0]                 receiver_kill_acks;
  logic [TOTAL_BUSES-1:0]                 receiver_incept_acks;
  logic [TOTAL_BUSES-1:0]                 receiver_send_acks;
  logic [TOTAL_BUSES-1:0]                 receiver_stream_acks;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [1:0]                             out_kind;
  logic [BUS_SEL_WIDTH-1:0]               out_bus;
  logic [WORD_WIDTH-1:0]                  out_data;
  logic [WORD_WIDTH-1:0]                  out_permission;
  logic [WORD_WIDTH-1:0]                  out_address;

  modport slave (
    input  receiver_enables, receiver_kills, receiver_incepts, receiver_sends, receiver_streams,
    input  receiver_datas, receiver_incept_permissions, receiver_incept_addresses, out_ready,
    output receiver_kill_acks, receiver_incept_acks, receiver_send_acks, receiver_stream_acks,
    output out_valid, out_kind, out_bus, out_data, out_permission, out_address
  );

  modport master (
    output receiver_enables, receiver_kills, receiver_incepts, receiver_sends, receiver_streams,
    output receiver_datas, receiver_incept_permissions, receiver_incept_addresses, out_ready,
    input  receiver_kill_acks, receiver_incept_acks, receiver_send_acks, receiver_stream_acks,
    input  out_valid, out_kind, out_bus, out_data, out_permission, out_address
  );
endinterface

// File: rtl/uarc_receiver_arbiter.sv
// Round-robin arbiter sharing the core's inbound message path among UARC receiver buses.
// Optional UARC_ARB_KILL_PREEMPT_EN: eligible kills beat all other requests in IDLE.
module uarc_receiver_arbiter #(
  parameter int WORD_MAG    = 5,
  parameter int TOTAL_BUSES = 4
) (
  input logic                    clk,
  input logic                    reset,
  uarc_receiver_arbiter_if.slave bus_if
);
  localparam int WORD_WIDTH    = 1 << WORD_MAG;
  localparam int BUS_SEL_WIDTH = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

  typedef enum logic [1:0] {IDLE, OFFER, ACK} state_t;

  state_t                   state_reg, state_next;
  logic [BUS_SEL_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [BUS_SEL_WIDTH-1:0] bus_reg, bus_next;
  logic [1:0]               kind_reg, kind_next;
  logic [WORD_WIDTH-1:0]    data_reg, data_next;
  logic [WORD_WIDTH-1:0]    perm_reg, perm_next;
  logic [WORD_WIDTH-1:0]    addr_reg, addr_next;
  logic                     valid_reg, valid_next;
  logic [3:0][TOTAL_BUSES-1:0] ack_reg, ack_next;

  logic [TOTAL_BUSES-1:0]      eligible, kill_eligible;
  logic [TOTAL_BUSES-1:0][1:0] bus_kind;
  logic [BUS_SEL_WIDTH:0]      pick;
  logic                        grant_found;
  logic [BUS_SEL_WIDTH-1:0]    grant_idx;

  genvar gi, gk;
  generate
    for (gi = 0; gi < TOTAL_BUSES; gi++) begin : g_req
      assign eligible[gi]      = bus_if.receiver_enables[gi] &
                                 (bus_if.receiver_kills[gi] | bus_if.receiver_incepts[gi] |
                                  bus_if.receiver_sends[gi] | bus_if.receiver_streams[gi]);
      assign kill_eligible[gi] = bus_if.receiver_enables[gi] & bus_if.receiver_kills[gi];
      assign bus_kind[gi]      = bus_if.receiver_kills[gi]   ? 2'd0 :
                                 bus_if.receiver_incepts[gi] ? 2'd1 :
                                 bus_if.receiver_sends[gi]   ? 2'd2 : 2'd3;
    end
  endgenerate

  // Returns {found, index}; scanning offsets high-to-low lets the smallest offset win.
  function automatic logic [BUS_SEL_WIDTH:0] rr_pick(input logic [TOTAL_BUSES-1:0] req,
                                                     input logic [BUS_SEL_WIDTH-1:0] ptr);
    logic [BUS_SEL_WIDTH:0] result;
    int idx;
    result = '0;
    for (int k = TOTAL_BUSES - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % TOTAL_BUSES;
      if (req[idx]) result = {1'b1, BUS_SEL_WIDTH'(idx)};
    end
    return result;
  endfunction

`ifdef UARC_ARB_KILL_PREEMPT_EN
  assign pick = (|kill_eligible) ? rr_pick(kill_eligible, rr_ptr_reg) : rr_pick(eligible, rr_ptr_reg);
`else
  assign pick = rr_pick(eligible, rr_ptr_reg);
`endif
  assign grant_found = pick[BUS_SEL_WIDTH];
  assign grant_idx   = pick[BUS_SEL_WIDTH-1:0];

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    bus_next    = bus_reg;
    kind_next   = kind_reg;
    data_next   = data_reg;
    perm_next   = perm_reg;
    addr_next   = addr_reg;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          state_next = OFFER;
          bus_next   = grant_idx;
          kind_next  = bus_kind[grant_idx];
          data_next  = bus_if.receiver_datas[grant_idx];
          perm_next  = (bus_kind[grant_idx] == 2'd1) ? bus_if.receiver_incept_permissions[grant_idx] : '0;
          addr_next  = (bus_kind[grant_idx] == 2'd1) ? bus_if.receiver_incept_addresses[grant_idx] : '0;
        end
      end
      OFFER: begin
        // A withdrawn request aborts even if the core accepts in the same cycle.
        if (!bus_if.receiver_enables[bus_reg]) begin
          state_next = IDLE;
        end else if (bus_if.out_ready) begin
          state_next  = ACK;
          rr_ptr_next = (bus_reg == BUS_SEL_WIDTH'(TOTAL_BUSES - 1)) ? '0 : bus_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    valid_next = (state_next == OFFER);
  end

  generate
    for (gk = 0; gk < 4; gk++) begin : g_ack_kind
      for (gi = 0; gi < TOTAL_BUSES; gi++) begin : g_ack_bus
        assign ack_next[gk][gi] = (state_next == ACK) && (bus_next == BUS_SEL_WIDTH'(gi)) &&
                                  (kind_next == 2'(gk));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      bus_reg    <= '0;
      kind_reg   <= '0;
      data_reg   <= '0;
      perm_reg   <= '0;
      addr_reg   <= '0;
      valid_reg  <= 1'b0;
      ack_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      bus_reg    <= bus_next;
      kind_reg   <= kind_next;
      data_reg   <= data_next;
      perm_reg   <= perm_next;
      addr_reg   <= addr_next;
      valid_reg  <= valid_next;
      ack_reg    <= ack_next;
    end
  end

  assign bus_if.out_valid            = valid_reg;
  assign bus_if.out_kind             = kind_reg;
  assign bus_if.out_bus              = bus_reg;
  assign bus_if.out_data             = data_reg;
  assign bus_if.out_permission       = perm_reg;
  assign bus_if.out_address          = addr_reg;
  assign bus_if.receiver_kill_acks   = ack_reg[0];
  assign bus_if.receiver_incept_acks = ack_reg[1];
  assign bus_if.receiver_send_acks   = ack_reg[2];
  assign bus_if.receiver_stream_acks = ack_reg[3];
endmodule
